// File: rtl/axi4_sram_pkg.sv
// Shared types and constants for the AXI4 SRAM slave.
// Optional feature macro: AXI4_SRAM_WRAP_EN (enables WRAP burst support).
`ifndef PROC_PALEN
`define PROC_PALEN 32
`endif

package axi4_sram_pkg;

    localparam int ADDR_W = `PROC_PALEN;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        WRESP,
        RDATA
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI4_SRAM_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    // A burst flagged here runs all its beats but never touches the store.
    function automatic logic burst_err(input logic [1:0] burst,
                                       input logic [7:0] len,
                                       input logic [2:0] size);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > 3'd2) || (burst == 2'b11) ||
               ((burst == BURST_WRAP) && (!WRAP_EN || !wrap_len_ok));
    endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 bus bundle with Master and Slave modports.
`ifndef PROC_PALEN
`define PROC_PALEN 32
`endif

interface AXI4 #(
    parameter int ADDR_WIDTH = `PROC_PALEN,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1
) ();
    logic                    aw_valid, aw_ready;
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;

    logic                    w_valid, w_ready, w_last;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;

    logic                    b_valid, b_ready;
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;

    logic                    ar_valid, ar_ready;
    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;

    logic                    r_valid, r_ready, r_last;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic [USER_WIDTH-1:0]   r_user;

    modport Slave (
        input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_id, b_resp, b_user,
        input  b_ready,
        input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
        output ar_ready,
        output r_valid, r_id, r_data, r_resp, r_last, r_user,
        input  r_ready
    );

    modport Master (
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_id, b_resp, b_user,
        output b_ready,
        output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
        input  ar_ready,
        input  r_valid, r_id, r_data, r_resp, r_last, r_user,
        output r_ready
    );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Combinational AXI4 next-beat address for FIXED, INCR and WRAP bursts.
module axi4_burst_addr_gen
    import axi4_sram_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr
);
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wrap_mask;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        step      = ADDR_W'(1) << size;
        incr      = addr + step;
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        next_addr = incr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
            default:     next_addr = incr;
        endcase
    end
endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 slave in front of a 32-bit word store; one transaction at a time.
// WRAP bursts depend on AXI4_SRAM_WRAP_EN (see axi4_sram_pkg).
module axi4_sram_slave
    import axi4_sram_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int ID_WIDTH  = 4
) (
    input  logic clk,
    input  logic a_rst_n,
    AXI4.Slave   axi4_slv
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    state_t              state, next_state;
    logic                wr_pri;
    logic [ID_WIDTH-1:0] id_q;
    logic [ADDR_W-1:0]   addr_q, next_addr;
    logic [7:0]          len_q, beat_q;
    logic [2:0]          size_q;
    logic [1:0]          burst_q;
    logic                cfg_err, resp_err, over_len;
    logic [31:0]         mem [MEM_WORDS];
    logic [31:0]         rd_data;

    logic grant_w, grant_r, accept;
    logic aw_hs, ar_hs, w_hs, r_hs, last_beat, aw_err, ar_err;

    // Round-robin: whoever was granted last yields on the next collision.
    assign grant_w   = axi4_slv.aw_valid && (!axi4_slv.ar_valid || wr_pri);
    assign grant_r   = axi4_slv.ar_valid && !grant_w;
    assign accept    = a_rst_n && (state == IDLE);
    assign aw_hs     = accept && grant_w;
    assign ar_hs     = accept && grant_r;
    assign w_hs      = (state == WDATA) && axi4_slv.w_valid;
    assign r_hs      = (state == RDATA) && axi4_slv.r_ready;
    assign last_beat = (beat_q == len_q);
    assign aw_err    = burst_err(axi4_slv.aw_burst, axi4_slv.aw_len, axi4_slv.aw_size);
    assign ar_err    = burst_err(axi4_slv.ar_burst, axi4_slv.ar_len, axi4_slv.ar_size);

    axi4_burst_addr_gen u_addr_gen (
        .addr      (addr_q),
        .len       (len_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (aw_hs) next_state = WDATA;
                     else if (ar_hs) next_state = RDATA;
            WDATA:   if (w_hs && axi4_slv.w_last) next_state = WRESP;
            WRESP:   if (axi4_slv.b_ready) next_state = IDLE;
            RDATA:   if (r_hs && last_beat) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        axi4_slv.aw_ready = aw_hs;
        axi4_slv.ar_ready = ar_hs;
        axi4_slv.w_ready  = 1'b0;
        axi4_slv.b_valid  = 1'b0;
        axi4_slv.b_resp   = RESP_OKAY;
        axi4_slv.r_valid  = 1'b0;
        axi4_slv.r_last   = 1'b0;
        axi4_slv.r_resp   = RESP_OKAY;
        case (state)
            WDATA: axi4_slv.w_ready = 1'b1;
            WRESP: begin
                axi4_slv.b_valid = 1'b1;
                axi4_slv.b_resp  = resp_err ? RESP_SLVERR : RESP_OKAY;
            end
            RDATA: begin
                axi4_slv.r_valid = 1'b1;
                axi4_slv.r_last  = last_beat;
                axi4_slv.r_resp  = resp_err ? RESP_SLVERR : RESP_OKAY;
            end
            default: ;
        endcase
    end

    assign axi4_slv.b_id   = id_q;
    assign axi4_slv.r_id   = id_q;
    assign axi4_slv.r_data = rd_data;
    assign axi4_slv.b_user = '0;
    assign axi4_slv.r_user = '0;

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            wr_pri   <= 1'b1;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            cfg_err  <= 1'b0;
            resp_err <= 1'b0;
            over_len <= 1'b0;
        end else if (aw_hs) begin
            wr_pri   <= 1'b0;
            id_q     <= axi4_slv.aw_id;
            addr_q   <= axi4_slv.aw_addr;
            len_q    <= axi4_slv.aw_len;
            size_q   <= axi4_slv.aw_size;
            burst_q  <= axi4_slv.aw_burst;
            beat_q   <= '0;
            cfg_err  <= aw_err;
            resp_err <= aw_err;
            over_len <= 1'b0;
        end else if (ar_hs) begin
            wr_pri   <= 1'b1;
            id_q     <= axi4_slv.ar_id;
            addr_q   <= axi4_slv.ar_addr;
            len_q    <= axi4_slv.ar_len;
            size_q   <= axi4_slv.ar_size;
            burst_q  <= axi4_slv.ar_burst;
            beat_q   <= '0;
            cfg_err  <= ar_err;
            resp_err <= ar_err;
            over_len <= 1'b0;
        end else if (w_hs) begin
            addr_q <= next_addr;
            // Early w_last or a missing w_last at beat len both turn the response into SLVERR.
            if (!over_len) begin
                if (last_beat) begin
                    if (!axi4_slv.w_last) begin
                        over_len <= 1'b1;
                        resp_err <= 1'b1;
                    end
                end else begin
                    beat_q <= beat_q + 8'd1;
                    if (axi4_slv.w_last) resp_err <= 1'b1;
                end
            end
        end else if (r_hs) begin
            addr_q <= next_addr;
            beat_q <= beat_q + 8'd1;
        end
    end

    // NOTE: the store and its read register have no reset; contents survive a_rst_n.
    always_ff @(posedge clk) begin
        if (w_hs && !over_len && !cfg_err) begin
            for (int b = 0; b < 4; b++) begin
                if (axi4_slv.w_strb[b])
                    mem[addr_q[2 +: IDX_W]][8*b +: 8] <= axi4_slv.w_data[8*b +: 8];
            end
        end
        if (ar_hs)
            rd_data <= ar_err ? 32'h0 : mem[axi4_slv.ar_addr[2 +: IDX_W]];
        else if (r_hs && !last_beat)
            rd_data <= cfg_err ? 32'h0 : mem[next_addr[2 +: IDX_W]];
    end
endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave with a response scoreboard and a word model.
module tb_axi4_sram_slave;
    import axi4_sram_pkg::*;

    logic clk = 1'b0;
    logic a_rst_n = 1'b0;
    always #5 clk = ~clk;

    AXI4 #(.ADDR_WIDTH(ADDR_W), .DATA_WIDTH(32), .ID_WIDTH(4), .USER_WIDTH(1)) bus ();

    axi4_sram_slave #(.MEM_WORDS(4096), .ID_WIDTH(4)) dut (
        .clk      (clk),
        .a_rst_n  (a_rst_n),
        .axi4_slv (bus.Slave)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  resp;
        logic [3:0]  id;
    } rexp_t;
    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t       rq[$];
    bexp_t       bq[$];
    logic [31:0] model [int];
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] w;
        w = model.exists(int'(addr[13:2])) ? model[int'(addr[13:2])] : 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
        model[int'(addr[13:2])] = w;
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] addr);
        return model.exists(int'(addr[13:2])) ? model[int'(addr[13:2])] : 32'h0;
    endfunction

    task automatic push_r(input logic [31:0] data, input logic last, input logic [1:0] resp, input logic [3:0] id);
        rq.push_back('{data: data, last: last, resp: resp, id: id});
    endtask

    task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
        bq.push_back('{id: id, resp: resp});
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output int waited);
        bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len; bus.aw_size = size; bus.aw_burst = burst;
        bus.aw_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!bus.aw_ready && waited < 50) begin @(negedge clk); waited++; end
        check("aw_handshake", 32'(waited < 50), 32'd1);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output int waited);
        bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len; bus.ar_size = size; bus.ar_burst = burst;
        bus.ar_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!bus.ar_ready && waited < 50) begin @(negedge clk); waited++; end
        check("ar_handshake", 32'(waited < 50), 32'd1);
        check("r_valid_at_ar", 32'(bus.r_valid), 32'd0);
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        check("r_valid_1cyc", 32'(bus.r_valid), 32'd1);
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        bus.w_data = data; bus.w_strb = strb; bus.w_last = last; bus.w_valid = 1'b1;
        @(negedge clk);
        while (!bus.w_ready && n < 50) begin @(negedge clk); n++; end
        check("w_handshake", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        bus.w_valid = 1'b0; bus.w_last = 1'b0;
    endtask

    task automatic b_recv();
        int    n = 0;
        bexp_t e;
        bus.b_ready = 1'b1;
        @(negedge clk);
        while (!bus.b_valid && n < 50) begin @(negedge clk); n++; end
        check("b_timeout", 32'(n < 50), 32'd1);
        if (bq.size() > 0) begin
            e = bq.pop_front();
            check("b_id", 32'(bus.b_id), 32'(e.id));
            check("b_resp", 32'(bus.b_resp), 32'(e.resp));
            check("b_user", 32'(bus.b_user), 32'd0);
        end
        @(posedge clk); #1;
        bus.b_ready = 1'b0;
    endtask

    task automatic r_recv(input int n, input bit toggle);
        int          got = 0;
        int          cyc = 0;
        logic [31:0] held;
        logic        held_last = 1'b0;
        bit          have_held = 1'b0;
        rexp_t       e;
        bus.r_ready = 1'b1;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            if (have_held) begin
                check("r_hold_data", bus.r_data, held);
                check("r_hold_last", 32'(bus.r_last), 32'(held_last));
                have_held = 1'b0;
            end
            if (bus.r_valid && bus.r_ready && rq.size() > 0) begin
                e = rq.pop_front();
                check("r_data", bus.r_data, e.data);
                check("r_last", 32'(bus.r_last), 32'(e.last));
                check("r_resp", 32'(bus.r_resp), 32'(e.resp));
                check("r_id", 32'(bus.r_id), 32'(e.id));
                check("r_user", 32'(bus.r_user), 32'd0);
                got++;
            end else if (bus.r_valid && !bus.r_ready) begin
                held = bus.r_data; held_last = bus.r_last; have_held = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            if (toggle) bus.r_ready = ~bus.r_ready;
        end
        bus.r_ready = 1'b0;
        check("r_beats", 32'(got), 32'(n));
        if (!toggle) check("r_rate", 32'(cyc), 32'(n));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_aw_ready"}, 32'(bus.aw_ready), 32'd0);
        check({tag, "_ar_ready"}, 32'(bus.ar_ready), 32'd0);
        check({tag, "_w_ready"},  32'(bus.w_ready),  32'd0);
        check({tag, "_b_valid"},  32'(bus.b_valid),  32'd0);
        check({tag, "_r_valid"},  32'(bus.r_valid),  32'd0);
        check({tag, "_r_last"},   32'(bus.r_last),   32'd0);
        check({tag, "_b_resp"},   32'(bus.b_resp),   32'd0);
        check({tag, "_r_resp"},   32'(bus.r_resp),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int                w;
        logic [31:0]       wdat [4];
        wdat = '{32'h11, 32'h22, 32'h33, 32'h44};
        bus.aw_valid = 0; bus.aw_id = 0; bus.aw_addr = 0; bus.aw_len = 0; bus.aw_size = 0; bus.aw_burst = 0;
        bus.ar_valid = 0; bus.ar_id = 0; bus.ar_addr = 0; bus.ar_len = 0; bus.ar_size = 0; bus.ar_burst = 0;
        bus.w_valid = 0; bus.w_data = 0; bus.w_strb = 0; bus.w_last = 0;
        bus.b_ready = 0; bus.r_ready = 0;

        // Reset state, with requests pending so ready gating is exercised.
        bus.aw_valid = 1'b1; bus.ar_valid = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("rst");
        bus.aw_valid = 1'b0; bus.ar_valid = 1'b0;
        @(posedge clk); #1;
        a_rst_n = 1'b1;

        // Write then read an INCR burst.
        aw_send(4'd1, 32'h100, 8'd3, 3'd2, BURST_INCR, w);
        for (int i = 0; i < 4; i++) begin
            w_send(wdat[i], 4'hF, i == 3);
            model_wr(32'h100 + 32'(4*i), wdat[i], 4'hF);
        end
        push_b(4'd1, RESP_OKAY);
        b_recv();
        for (int i = 0; i < 4; i++) push_r(wdat[i], i == 3, RESP_OKAY, 4'd2);
        ar_send(4'd2, 32'h100, 8'd3, 3'd2, BURST_INCR, w);
        r_recv(4, 1'b0);

        // Byte-strobed partial write.
        aw_send(4'd3, 32'h200, 8'd0, 3'd2, BURST_INCR, w);
        w_send(32'hAABBCCDD, 4'hF, 1'b1);
        push_b(4'd3, RESP_OKAY); b_recv();
        aw_send(4'd3, 32'h200, 8'd0, 3'd2, BURST_INCR, w);
        w_send(32'h00000011, 4'h1, 1'b1);
        push_b(4'd3, RESP_OKAY); b_recv();
        model_wr(32'h200, 32'hAABBCC11, 4'hF);
        push_r(32'hAABBCC11, 1'b1, RESP_OKAY, 4'd4);
        ar_send(4'd4, 32'h200, 8'd0, 3'd2, BURST_INCR, w);
        r_recv(1, 1'b0);

        // WRAP read starting mid-window.
`ifdef AXI4_SRAM_WRAP_EN
        push_r(32'h44, 1'b0, RESP_OKAY, 4'd5);
        push_r(32'h11, 1'b0, RESP_OKAY, 4'd5);
        push_r(32'h22, 1'b0, RESP_OKAY, 4'd5);
        push_r(32'h33, 1'b1, RESP_OKAY, 4'd5);
`else
        for (int i = 0; i < 4; i++) push_r(32'h0, i == 3, RESP_SLVERR, 4'd5);
`endif
        ar_send(4'd5, 32'h10C, 8'd3, 3'd2, BURST_WRAP, w);
        r_recv(4, 1'b0);

        // Oversized beat: zero data, SLVERR, full length.
        push_r(32'h0, 1'b0, RESP_SLVERR, 4'd6);
        push_r(32'h0, 1'b1, RESP_SLVERR, 4'd6);
        ar_send(4'd6, 32'h100, 8'd1, 3'd3, BURST_INCR, w);
        r_recv(2, 1'b0);

        // High address bits alias onto the same word.
        push_r(32'h11, 1'b1, RESP_OKAY, 4'd7);
        ar_send(4'd7, 32'h4100, 8'd0, 3'd2, BURST_INCR, w);
        r_recv(1, 1'b0);

        // Early w_last.
        aw_send(4'd8, 32'h300, 8'd3, 3'd2, BURST_INCR, w);
        w_send(32'hB0, 4'hF, 1'b0);
        w_send(32'hB1, 4'hF, 1'b1);
        push_b(4'd8, RESP_SLVERR); b_recv();

        // Missing w_last at beat len; the extra beat must not land in the store.
        aw_send(4'd9, 32'h408, 8'd0, 3'd2, BURST_INCR, w);
        w_send(32'h5555AAAA, 4'hF, 1'b1);
        push_b(4'd9, RESP_OKAY); b_recv();
        model_wr(32'h408, 32'h5555AAAA, 4'hF);
        aw_send(4'd9, 32'h400, 8'd1, 3'd2, BURST_INCR, w);
        w_send(32'hA0, 4'hF, 1'b0);
        w_send(32'hA1, 4'hF, 1'b0);
        w_send(32'hA2, 4'hF, 1'b1);
        push_b(4'd9, RESP_SLVERR); b_recv();
        model_wr(32'h400, 32'hA0, 4'hF);
        model_wr(32'h404, 32'hA1, 4'hF);
        for (int i = 0; i < 3; i++) push_r(model_rd(32'h400 + 32'(4*i)), i == 2, RESP_OKAY, 4'd10);
        ar_send(4'd10, 32'h400, 8'd2, 3'd2, BURST_INCR, w);
        r_recv(3, 1'b0);

        // Stalled read with r_ready toggling.
        for (int i = 0; i < 4; i++) push_r(model_rd(32'h100 + 32'(4*i)), i == 3, RESP_OKAY, 4'd11);
        ar_send(4'd11, 32'h100, 8'd3, 3'd2, BURST_INCR, w);
        r_recv(4, 1'b1);

        // Last grant is a write, then reset must restore write priority.
        aw_send(4'd12, 32'h600, 8'd0, 3'd2, BURST_INCR, w);
        w_send(32'h66, 4'hF, 1'b1);
        push_b(4'd12, RESP_OKAY); b_recv();
        model_wr(32'h600, 32'h66, 4'hF);
        a_rst_n = 1'b0;
        bus.aw_id = 4'd3; bus.aw_addr = 32'h700; bus.aw_len = 8'd0; bus.aw_size = 3'd2; bus.aw_burst = BURST_INCR;
        bus.ar_id = 4'd5; bus.ar_addr = 32'h100; bus.ar_len = 8'd3; bus.ar_size = 3'd2; bus.ar_burst = BURST_INCR;
        bus.aw_valid = 1'b1; bus.ar_valid = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst2");
        @(posedge clk); #1;
        a_rst_n = 1'b1;
        @(negedge clk);
        check("conc_aw_ready", 32'(bus.aw_ready), 32'd1);
        check("conc_ar_ready", 32'(bus.ar_ready), 32'd0);
        @(posedge clk); #1;
        bus.aw_valid = 1'b0;
        for (int i = 0; i < 4; i++) push_r(model_rd(32'h100 + 32'(4*i)), i == 3, RESP_OKAY, 4'd5);
        #1 check("conc_ar_held_off", 32'(bus.ar_ready), 32'd0);
        w_send(32'h77, 4'hF, 1'b1);
        model_wr(32'h700, 32'h77, 4'hF);
        push_b(4'd3, RESP_OKAY); b_recv();
        bus.aw_id = 4'd4; bus.aw_addr = 32'h704; bus.aw_valid = 1'b1;
        @(negedge clk);
        check("rr_ar_ready", 32'(bus.ar_ready), 32'd1);
        check("rr_aw_ready", 32'(bus.aw_ready), 32'd0);
        @(posedge clk); #1;
        bus.ar_valid = 1'b0;
        r_recv(4, 1'b0);
        aw_send(4'd4, 32'h704, 8'd0, 3'd2, BURST_INCR, w);
        w_send(32'h78, 4'hF, 1'b1);
        model_wr(32'h704, 32'h78, 4'hF);
        push_b(4'd4, RESP_OKAY); b_recv();

        // Reset pulse in the middle of a read burst.
        ar_send(4'd6, 32'h700, 8'd3, 3'd2, BURST_INCR, w);
        bus.r_ready = 1'b1;
        @(negedge clk);
        check("abort_beat0", bus.r_data, model_rd(32'h700));
        @(posedge clk); #1;
        a_rst_n = 1'b0;
        #1 check("abort_r_valid", 32'(bus.r_valid), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("abort_in_rst", 32'(bus.r_valid), 32'd0);
        end
        @(posedge clk); #1;
        a_rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_beats", 32'(bus.r_valid), 32'd0);
        end
        @(posedge clk); #1;
        bus.r_ready = 1'b0;
        push_r(32'h78, 1'b1, RESP_OKAY, 4'd7);
        ar_send(4'd7, 32'h704, 8'd0, 3'd2, BURST_INCR, w);
        check("post_rst_first_edge", 32'(w), 32'd0);
        r_recv(1, 1'b0);
        check("scoreboard_empty", 32'(rq.size() + bq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi4_sram_slave.md
AXI4_SRAM_SLAVE -- requirements
Module: axi4_sram_slave

Interface
REQ-001 MEM_WORDS, 4096, depth of the 32-bit word store; power of two.
REQ-002 ID_WIDTH, 4, AXI ID width; equals the ID width of the bus bundle.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 a_rst_n  input  1  asynchronous, active-low reset.
REQ-005 axi4_slv  AXI4.Slave modport  bundle (ADDR `PROC_PALEN, DATA 32, ID 4, USER 1)  responder end of the AXI4 bus driven by the core interconnect master port.

Function
REQ-006 The block SHALL use FSM states IDLE, WDATA, WRESP and RDATA, and SHALL process one transaction at a time.
REQ-007 IDLE, single request: the block SHALL assert only the ready of the requesting channel (aw_ready or ar_ready).
- Simultaneous aw_valid and ar_valid: round-robin grant; write wins after reset.
- Handshake: capture id, addr, len, size, burst.
- Transitions: AW handshake -> WDATA; AR handshake -> RDATA.
REQ-008 WDATA: w_ready SHALL be 1; each beat SHALL write the bytes enabled by w_strb to word index addr[2 +: log2(MEM_WORDS)]; the address SHALL advance once per beat.
REQ-009 WDATA end and error marking:
- Exit to WRESP on the beat carrying w_last.
- w_last before beat len, or no w_last by beat len: mark SLVERR.
- Beats beyond len: not written.
REQ-010 WRESP: b_valid=1, b_id=captured id, b_resp=OKAY(00) or SLVERR(10); hold until b_ready; then IDLE.
REQ-011 RDATA read behaviour:
- Store read is synchronous; first r_valid exactly 1 cycle after the AR handshake.
- r_data, r_id and r_last held stable while r_valid=1 and r_ready=0.
- With r_ready held high: one beat per cycle.
- r_last=1 on beat len; IDLE after that beat is accepted.
REQ-012 Address sequencing:
- FIXED: no increment.
- INCR: add 1<<size.
- WRAP: wrap at the aligned boundary of (len+1)<<size; legal len is 1, 3, 7 or 15; other len gives SLVERR.
REQ-013 size>2: SLVERR; the block SHALL perform no store writes, return read data 0, and still run the full len+1 beats.
REQ-014 Address bits above log2(MEM_WORDS)+1 SHALL be ignored (aliasing); no decode error.
REQ-015 Read r_resp SHALL be constant per burst (OKAY or SLVERR); b_user and r_user SHALL be 0.

Reset
REQ-016 While a_rst_n=0, the block SHALL:
- drive all valid and ready outputs to 0;
- set state IDLE and grant priority to write;
- set r_last=0 and b_resp=r_resp=00;
- leave store contents unchanged and not reset.
REQ-017 Reset during a burst SHALL abort it with no response; after release, IDLE accepts new requests on the first edge.

Configuration
REQ-018 Macro AXI4_SRAM_WRAP_EN:
- Defined: WRAP bursts supported per REQ-012.
- Undefined: WRAP bursts are accepted and run all beats, with no store writes, read data 0 and SLVERR response.

Structure
REQ-019 Package axi4_sram_pkg SHALL hold:
- FSM state enum;
- burst constants FIXED=00, INCR=01, WRAP=10;
- response constants OKAY=00, SLVERR=10.
REQ-020 Next-address arithmetic SHALL be a combinational sub-module axi4_burst_addr_gen (inputs addr, len, size, burst; output next addr).

Verification
REQ-021 Write then read:
- AW addr 0x100, INCR, len 3, size 2, data 0x11..0x44, strb 0xF -> b_resp 00.
- AR of the same burst -> 0x11, 0x22, 0x33, 0x44; r_last on the 4th beat; first r_valid 1 cycle after the AR handshake.
REQ-022 Partial write: word 0x200=0xAABBCCDD, then write 0x00000011 with strb 0x1 -> read back 0xAABBCC11.
REQ-023 WRAP: addr 0x10C, len 3, size 2 -> beats at 0x10C, 0x100, 0x104, 0x108; with the macro undefined -> r_resp 10 and data 0.
REQ-024 Concurrency: aw_valid and ar_valid asserted in the same cycle after reset -> write granted first, read granted next.
- r_ready toggled every cycle -> r_data stable while stalled.
REQ-025 Error and reset:
- w_last on beat 1 of a len 3 burst -> b_resp 10.
- a_rst_n pulse during RDATA -> r_valid 0 immediately, no further beats.
